// File: rtl/mc_pkg.sv
// Shared definitions for the memory-controller slice: request word layout,
// DRAM command encodings and the command generator's FSM states.
package mc_pkg;

    // Request word field positions (68-bit word from scheduled_buffer)
    localparam int VALID_B  = 67;
    localparam int WR_B     = 66;
    localparam int BANK_HI  = 65;
    localparam int BANK_LO  = 64;
    localparam int ROW_HI   = 63;
    localparam int ROW_LO   = 48;
    localparam int COL_HI   = 47;
    localparam int COL_LO   = 32;
    localparam int WDATA_HI = 31;
    localparam int WDATA_LO = 0;

    // DRAM command encodings on the cmd pins
    typedef enum logic [2:0] {
        CmdNop = 3'd0,
        CmdAct = 3'd1,
        CmdRd  = 3'd2,
        CmdWr  = 3'd3,
        CmdPre = 3'd4
    } cmd_e;

    // Command generator FSM states
    typedef enum logic [3:0] {
        StIdle,
        StPre,
        StWaitRp,
        StAct,
        StWaitRcd,
        StRdwr,
        StWaitCas,
        StRetire,
        StSettle
    } state_e;

endpackage

// File: rtl/command_generator.sv
// DRAM command generator: pulls the head request from scheduled_buffer,
// sequences PRE/ACT/RD/WR with programmable timing and retires the entry
// with a single inc pulse. Keeps one page open using next_row_out as lookahead.
module command_generator
    import mc_pkg::*;
#(
    parameter int unsigned T_RCD = 3,
    parameter int unsigned T_CAS = 4,
    parameter int unsigned T_RP  = 3,
    parameter int unsigned CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [67:0] request_out,
    input  logic [15:0] next_row_out,
    input  logic [31:0] rd_data_in,
    output logic        inc,
    output logic [2:0]  cmd,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_addr,
    output logic [31:0] cmd_wdata,
    output logic [31:0] rd_data_out,
    output logic        rd_valid,
    output logic        busy
);

    state_e             state;
    logic [CNT_W-1:0]   counter;
    logic               row_open;
    logic [15:0]        open_row;
    logic [1:0]         open_bank;

    logic               req_valid;
    logic               req_wr;
    logic [1:0]         req_bank;
    logic [15:0]        req_row;
    logic [15:0]        req_col;
    logic [31:0]        req_wdata;
    logic               page_hit;

    assign req_valid = request_out[VALID_B];
    assign req_wr    = request_out[WR_B];
    assign req_bank  = request_out[BANK_HI:BANK_LO];
    assign req_row   = request_out[ROW_HI:ROW_LO];
    assign req_col   = request_out[COL_HI:COL_LO];
    assign req_wdata = request_out[WDATA_HI:WDATA_LO];
    assign page_hit  = row_open && (req_bank == open_bank) && (req_row == open_row);

    // FSM, timing counter, open-page tracking and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            counter     <= '0;
            row_open    <= 1'b0;
            open_row    <= '0;
            open_bank   <= '0;
            inc         <= 1'b0;
            cmd         <= CmdNop;
            cmd_bank    <= '0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            rd_data_out <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Command and pulse outputs default to idle every cycle
            inc       <= 1'b0;
            cmd       <= CmdNop;
            cmd_bank  <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rd_valid  <= 1'b0;
            busy      <= (state != StIdle);

            unique case (state)
                StIdle: begin
                    if (!req_valid) begin
                        // Empty slot: retire it so the buffer can drain/reload
                        inc   <= 1'b1;
                        state <= StSettle;
                    end else if (page_hit) begin
                        state <= StRdwr;
                    end else if (row_open) begin
                        state <= StPre;
                    end else begin
                        state <= StAct;
                    end
                end
                StPre: begin
                    cmd      <= CmdPre;
                    cmd_bank <= open_bank;
                    row_open <= 1'b0;
                    counter  <= CNT_W'(T_RP - 1);
                    state    <= StWaitRp;
                end
                StWaitRp: begin
                    // Leaving as the count reaches 0 puts ACT exactly T_RP after PRE
                    if (counter <= CNT_W'(1)) begin
                        counter <= '0;
                        // After an early close the new head may be an empty slot
                        state   <= req_valid ? StAct : StIdle;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                StAct: begin
                    cmd       <= CmdAct;
                    cmd_bank  <= req_bank;
                    cmd_addr  <= req_row;
                    row_open  <= 1'b1;
                    open_row  <= req_row;
                    open_bank <= req_bank;
                    counter   <= CNT_W'(T_RCD - 1);
                    state     <= StWaitRcd;
                end
                StWaitRcd: begin
                    if (counter <= CNT_W'(1)) begin
                        counter <= '0;
                        state   <= StRdwr;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                StRdwr: begin
                    cmd       <= req_wr ? CmdWr : CmdRd;
                    cmd_bank  <= req_bank;
                    cmd_addr  <= req_col;
                    cmd_wdata <= req_wdata;
                    counter   <= CNT_W'(T_CAS - 1);
                    state     <= StWaitCas;
                end
                StWaitCas: begin
                    // Count runs through 0 so capture lands T_CAS after RD
                    if (counter == '0) begin
                        if (!req_wr) begin
                            rd_data_out <= rd_data_in;
                            rd_valid    <= 1'b1;
                        end
                        state <= StRetire;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                StRetire: begin
                    inc   <= 1'b1;
                    state <= (next_row_out != open_row) ? StPre : StSettle;
                end
                StSettle: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
